// File: rtl/ysyx_25020047_pkg.sv
// Shared definitions for the NPC writeback arbiter: FSM encoding,
// source encoding and the writeback request record.
package ysyx_25020047_pkg;

  localparam int WB_XLEN  = 32;
  localparam int WB_RD_W  = 5;
  // Wide enough for the largest legal starvation limit (15).
  localparam int STARVE_W = 4;

  // Source encoding; also used as the bit index into the one-hot grant.
  localparam logic SRC_ALU = 1'b0;
  localparam logic SRC_LD  = 1'b1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LD_PRI    = 2'd1,
    ALU_FORCE = 2'd2
  } wb_state_e;

  typedef struct packed {
    logic [WB_RD_W-1:0] rd;
    logic [WB_XLEN-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/ysyx_25020047_wb_prio.sv
// Combinational grant selection for the writeback arbiter.
// Load-first unless the ALU has been starved (force_alu_i); nothing while held.
module ysyx_25020047_wb_prio
  import ysyx_25020047_pkg::*;
(
  input  logic       alu_valid_i,
  input  logic       ld_valid_i,
  input  logic       hold_i,
  input  logic       force_alu_i,
  output logic [1:0] gnt_o
);

  // One-hot grant, indexed by the source encoding.
  always_comb begin
    gnt_o = 2'b00;
    if (!hold_i) begin
      if (alu_valid_i && (!ld_valid_i || force_alu_i)) begin
        gnt_o[SRC_ALU] = 1'b1;
      end else if (ld_valid_i) begin
        gnt_o[SRC_LD] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ysyx_25020047_wb_arbiter.sv
// GPR write-port arbiter: ALU vs. load writeback, load-first with bounded
// ALU starvation, one registered output stage driving the regfile.
// Optional forwarding ports are enabled by YSYX_25020047_WB_FWD_EN.
module ysyx_25020047_wb_arbiter
  import ysyx_25020047_pkg::*;
#(
  parameter int XLEN         = WB_XLEN,
  parameter int RD_W         = WB_RD_W,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            hold,
  input  logic            alu_valid,
  input  logic [RD_W-1:0] alu_rd,
  input  logic [XLEN-1:0] alu_data,
  output logic            alu_ready,
  input  logic            ld_valid,
  input  logic [RD_W-1:0] ld_rd,
  input  logic [XLEN-1:0] ld_data,
  output logic            ld_ready,
  output logic            rf_wen,
  output logic [RD_W-1:0] rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic            retire_valid,
  output logic            retire_src
`ifdef YSYX_25020047_WB_FWD_EN
  ,
  output logic            fwd_valid,
  output logic [RD_W-1:0] fwd_rd,
  output logic [XLEN-1:0] fwd_data
`endif
);

  typedef struct packed {
    logic            v;
    logic            src;
    logic [RD_W-1:0] rd;
    logic [XLEN-1:0] data;
  } out_t;

  localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

  wb_state_e           state_q, state_d;
  logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;
  out_t                out_q, out_d;
  logic [1:0]          gnt;
  logic                block_grant;
  logic                any_valid;
  logic                starve_hit;

  // Readies must read 0 while reset is asserted even if a requester is valid.
  assign block_grant = hold || !rst_n;
  assign any_valid   = alu_valid || ld_valid;

  ysyx_25020047_wb_prio u_prio (
    .alu_valid_i (alu_valid),
    .ld_valid_i  (ld_valid),
    .hold_i      (block_grant),
    .force_alu_i (state_q == ALU_FORCE),
    .gnt_o       (gnt)
  );

  assign alu_ready = gnt[SRC_ALU];
  assign ld_ready  = gnt[SRC_LD];

  // Starvation count: grows while the ALU waits (hold included), saturates.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!alu_valid || gnt[SRC_ALU]) begin
      starve_cnt_d = '0;
    end else if (starve_cnt_q != LIMIT) begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end
  end

  assign starve_hit = alu_valid && (starve_cnt_d == LIMIT);

  // Arbiter mode; ALU_FORCE is exactly the state where the counter sits at the limit.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (any_valid) state_d = starve_hit ? ALU_FORCE : LD_PRI;
      end
      LD_PRI: begin
        if (!any_valid)      state_d = IDLE;
        else if (starve_hit) state_d = ALU_FORCE;
      end
      ALU_FORCE: begin
        if (gnt[SRC_ALU] || !alu_valid) state_d = any_valid ? LD_PRI : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output stage next value: capture the winner, otherwise drain to empty.
  always_comb begin
    out_d   = out_q;
    out_d.v = 1'b0;
    if (gnt[SRC_ALU]) begin
      out_d = '{v: 1'b1, src: SRC_ALU, rd: alu_rd, data: alu_data};
    end else if (gnt[SRC_LD]) begin
      out_d = '{v: 1'b1, src: SRC_LD, rd: ld_rd, data: ld_data};
    end
  end

  // State registers; reset drops any pending writeback without writing it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      starve_cnt_q <= '0;
      out_q        <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      out_q        <= out_d;
    end
  end

  // Writes to x0 retire but never reach the regfile.
  assign rf_wen       = out_q.v && (out_q.rd != '0);
  assign rf_waddr     = out_q.rd;
  assign rf_wdata     = out_q.data;
  assign retire_valid = out_q.v;
  assign retire_src   = out_q.src;

`ifdef YSYX_25020047_WB_FWD_EN
  assign fwd_valid = out_q.v && (out_q.rd != '0);
  assign fwd_rd    = out_q.rd;
  assign fwd_data  = out_q.data;
`endif

endmodule

// File: tb/tb_ysyx_25020047_wb_arbiter.sv
// Scoreboard bench for the writeback arbiter (STARVE_LIMIT = 4).
module tb_ysyx_25020047_wb_arbiter;
  import ysyx_25020047_pkg::*;

  localparam int GN = 0;  // no grant expected
  localparam int GA = 1;  // ALU grant expected
  localparam int GL = 2;  // load grant expected

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        hold = 1'b0;
  logic        alu_valid = 1'b0;
  logic [4:0]  alu_rd = '0;
  logic [31:0] alu_data = '0;
  logic        alu_ready;
  logic        ld_valid = 1'b0;
  logic [4:0]  ld_rd = '0;
  logic [31:0] ld_data = '0;
  logic        ld_ready;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        retire_valid;
  logic        retire_src;
`ifdef YSYX_25020047_WB_FWD_EN
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;
`endif

  ysyx_25020047_wb_arbiter #(.XLEN(32), .RD_W(5), .STARVE_LIMIT(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .hold         (hold),
    .alu_valid    (alu_valid),
    .alu_rd       (alu_rd),
    .alu_data     (alu_data),
    .alu_ready    (alu_ready),
    .ld_valid     (ld_valid),
    .ld_rd        (ld_rd),
    .ld_data      (ld_data),
    .ld_ready     (ld_ready),
    .rf_wen       (rf_wen),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata),
    .retire_valid (retire_valid),
    .retire_src   (retire_src)
`ifdef YSYX_25020047_WB_FWD_EN
    ,
    .fwd_valid    (fwd_valid),
    .fwd_rd       (fwd_rd),
    .fwd_data     (fwd_data)
`endif
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned tgt;
    logic        src;
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every retire must match the oldest expected entry due this cycle.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].tgt < cyc) begin
      chk("missed_retire", 32'(exp_q[0].rd), 32'hFFFF_FFFF);
      void'(exp_q.pop_front());
    end
    if (exp_q.size() > 0 && exp_q[0].tgt == cyc) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("retire_valid", 32'(retire_valid), 32'd1);
      chk("retire_src",   32'(retire_src),   32'(e.src));
      chk("rf_waddr",     32'(rf_waddr),     32'(e.rd));
      chk("rf_wdata",     rf_wdata,          e.data);
      chk("rf_wen",       32'(rf_wen),       32'(e.rd != 5'd0));
`ifdef YSYX_25020047_WB_FWD_EN
      chk("fwd_valid",    32'(fwd_valid),    32'(e.rd != 5'd0));
      chk("fwd_data",     fwd_data,          e.data);
`endif
      $display("cycle %0d: retire src=%0d rd=%0d data=0x%08h wen=%0d", cyc, retire_src, rf_waddr, rf_wdata, rf_wen);
    end else begin
      chk("idle_retire", 32'(retire_valid), 32'd0);
      chk("idle_wen",    32'(rf_wen),       32'd0);
    end
  end

  // One cycle of stimulus with its hand-computed grant outcome.
  task automatic step(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                      input logic lv, input logic [4:0] lr, input logic [31:0] ldd,
                      input logic h, input int g);
    exp_t e;
    @(negedge clk);
    alu_valid = av; alu_rd = ar; alu_data = ad;
    ld_valid  = lv; ld_rd  = lr; ld_data  = ldd;
    hold = h;
    #1;
    chk("alu_ready", 32'(alu_ready), 32'(g == GA));
    chk("ld_ready",  32'(ld_ready),  32'(g == GL));
    if (g == GA) begin
      e = '{tgt: cyc + 1, src: SRC_ALU, rd: ar, data: ad};
      exp_q.push_back(e);
    end else if (g == GL) begin
      e = '{tgt: cyc + 1, src: SRC_LD, rd: lr, data: ldd};
      exp_q.push_back(e);
    end
  endtask

  task automatic idle_step();
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, GN);
  endtask

  initial begin
    // Reset with a valid request present: no ready may escape.
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h1;
    #12;
    chk("rst_alu_ready", 32'(alu_ready), 32'd0);
    chk("rst_rf_wen",    32'(rf_wen),    32'd0);
    chk("rst_waddr",     32'(rf_waddr),  32'd0);
    chk("rst_wdata",     rf_wdata,       32'd0);
    chk("rst_state",     32'(dut.state_q), 32'(IDLE));
    chk("rst_starve",    32'(dut.starve_cnt_q), 32'd0);
    alu_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // ALU only.
    step(1'b1, 5'd5, 32'h1234_5678, 1'b0, 5'd0, 32'd0, 1'b0, GA);
    idle_step();

    // Both valid: load first, ALU next cycle.
    step(1'b1, 5'd3, 32'hA, 1'b1, 5'd4, 32'hB, 1'b0, GL);
    step(1'b1, 5'd3, 32'hA, 1'b0, 5'd0, 32'd0, 1'b0, GA);
    idle_step();

    // Continuous loads: ALU wins on its 5th waiting cycle.
    for (int i = 0; i < 5; i++) begin
      if (i == 4) begin
        @(posedge clk); #1;
        chk("force_state", 32'(dut.state_q), 32'(ALU_FORCE));
      end
      step(1'b1, 5'd7, 32'h77, 1'b1, 5'(8 + i), 32'h100 + 32'(i), 1'b0, (i == 4) ? GA : GL);
    end
    @(posedge clk); #1;
    chk("starve_clear", 32'(dut.starve_cnt_q), 32'd0);
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 32'h104, 1'b0, GL);
    idle_step();

    // Load to x0: retires, no regfile write.
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hDEAD, 1'b0, GL);
    idle_step();

    // Load then hold rising with both valid; register drains meanwhile.
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd11, 32'hBB, 1'b0, GL);
    for (int i = 0; i < 5; i++)
      step(1'b1, 5'd9, 32'h99, 1'b1, 5'd10, 32'hAA, 1'b1, GN);
    @(posedge clk); #1;
    chk("starve_sat", 32'(dut.starve_cnt_q), 32'd4);
    step(1'b1, 5'd9, 32'h99, 1'b1, 5'd10, 32'hAA, 1'b0, GA);
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd10, 32'hAA, 1'b0, GL);
    idle_step();
    idle_step();
    chk("idle_state", 32'(dut.state_q), 32'(IDLE));

    // Asynchronous reset while the output register holds an entry.
    @(negedge clk);
    alu_valid = 1'b1; alu_rd = 5'd6; alu_data = 32'h66;
    #1;
    chk("pre_rst_ready", 32'(alu_ready), 32'd1);
    @(posedge clk); #1;
    chk("pre_rst_wen", 32'(rf_wen), 32'd1);
    #1;
    rst_n = 1'b0;
    alu_valid = 1'b0;
    #1;
    chk("rst_drop_wen",    32'(rf_wen),       32'd0);
    chk("rst_drop_retire", 32'(retire_valid), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_waddr", 32'(rf_waddr),   32'd0);
    chk("post_rst_wdata", rf_wdata,        32'd0);
    chk("post_rst_src",   32'(retire_src), 32'd0);
    chk("post_rst_state", 32'(dut.state_q), 32'(IDLE));
    chk("post_rst_cnt",   32'(dut.starve_cnt_q), 32'd0);

    idle_step();
    idle_step();
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
